// File: rtl/fault_campaign_sequencer.sv
// Fault campaign sequencer: sweeps fault codes and input vectors into a
// full-adder fault detector and accumulates per-fault detection results.
module fault_campaign_sequencer #(
    parameter int unsigned FIRST_FAULT    = 0,
    parameter int unsigned LAST_FAULT     = 7,
    parameter bit          STOP_ON_DETECT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       cin,
    output logic [2:0] fault_select,
    input  logic       fault_sum_detected,
    input  logic       fault_carry_detected,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum_mask,
    output logic [7:0] carry_mask,
    output logic [7:0] detected_mask,
    output logic [3:0] detect_count,
    output logic [6:0] vec_count
);

    localparam int unsigned VW      = 3;
    localparam int unsigned MW      = 8;
    localparam int unsigned CW      = 4;
    localparam int unsigned NW      = 7;
    localparam int unsigned VEC_MAX = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [VW-1:0]   flt_q, flt_d;
    logic [MW-1:0]   sum_q, sum_d;
    logic [MW-1:0]   carry_q, carry_d;
    logic [MW-1:0]   det_q, det_d;
    logic [CW-1:0]   dcnt_q, dcnt_d;
    logic [NW-1:0]   vcnt_q, vcnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            hit;
    logic            advance;

    assign hit     = fault_sum_detected | fault_carry_detected;
    assign advance = (vec_q == 3'd7) || (STOP_ON_DETECT && hit);

    // Next-state and result accumulation.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        flt_d   = flt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        det_d   = det_q;
        dcnt_d  = dcnt_q;
        vcnt_d  = vcnt_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                vec_d = '0;
                flt_d = '0;
                if (start) begin
                    sum_d   = '0;
                    carry_d = '0;
                    det_d   = '0;
                    dcnt_d  = '0;
                    vcnt_d  = '0;
                    flt_d   = VW'(FIRST_FAULT);
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (fault_sum_detected)   sum_d[flt_q]   = 1'b1;
                if (fault_carry_detected) carry_d[flt_q] = 1'b1;
                if (hit) begin
                    det_d[flt_q] = 1'b1;
                    // Count each fault only on its first detection.
                    if (!det_q[flt_q]) dcnt_d = dcnt_q + CW'(1);
                end
                if (vcnt_q != NW'(VEC_MAX)) vcnt_d = vcnt_q + NW'(1);

                if (advance) begin
                    vec_d = '0;
                    if (flt_q == VW'(LAST_FAULT)) begin
                        flt_d   = '0;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        flt_d = flt_q + VW'(1);
                    end
                end else begin
                    vec_d = vec_q + VW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                flt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            flt_q   <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            det_q   <= '0;
            dcnt_q  <= '0;
            vcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            flt_q   <= flt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            det_q   <= det_d;
            dcnt_q  <= dcnt_d;
            vcnt_q  <= vcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a             = vec_q[2];
    assign b             = vec_q[1];
    assign cin           = vec_q[0];
    assign fault_select  = flt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign sum_mask      = sum_q;
    assign carry_mask    = carry_q;
    assign detected_mask = det_q;
    assign detect_count  = dcnt_q;
    assign vec_count     = vcnt_q;

endmodule

// File: tb/tb_fault_campaign_sequencer.sv
// Scoreboard bench: three sequencer instances (default, no early stop,
// fault range 2..4) each driven by a behavioural detector stub.
module tb_fault_campaign_sequencer;

    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start [ND];
    logic       a     [ND];
    logic       b     [ND];
    logic       cin   [ND];
    logic [2:0] fs    [ND];
    logic       sd    [ND];
    logic       cd    [ND];
    logic       busy  [ND];
    logic       done  [ND];
    logic [7:0] sm    [ND];
    logic [7:0] cm    [ND];
    logic [7:0] dm    [ND];
    logic [3:0] dc    [ND];
    logic [6:0] vc    [ND];
    int         mode  [ND];

    // mode 0: never detects; 1: sum mismatch only at fault 3, vector 101; 2: both always
    function automatic logic stub_sum(int m, logic [2:0] f, logic [2:0] v);
        return (m == 2) || (m == 1 && f == 3'd3 && v == 3'b101);
    endfunction

    function automatic logic stub_carry(int m);
        return (m == 2);
    endfunction

    assign sd[0] = stub_sum(mode[0], fs[0], {a[0], b[0], cin[0]});
    assign sd[1] = stub_sum(mode[1], fs[1], {a[1], b[1], cin[1]});
    assign sd[2] = stub_sum(mode[2], fs[2], {a[2], b[2], cin[2]});
    assign cd[0] = stub_carry(mode[0]);
    assign cd[1] = stub_carry(mode[1]);
    assign cd[2] = stub_carry(mode[2]);

    fault_campaign_sequencer u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin[0]),
        .fault_select(fs[0]), .fault_sum_detected(sd[0]), .fault_carry_detected(cd[0]),
        .busy(busy[0]), .done(done[0]), .sum_mask(sm[0]), .carry_mask(cm[0]),
        .detected_mask(dm[0]), .detect_count(dc[0]), .vec_count(vc[0])
    );

    fault_campaign_sequencer #(.STOP_ON_DETECT(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .cin(cin[1]),
        .fault_select(fs[1]), .fault_sum_detected(sd[1]), .fault_carry_detected(cd[1]),
        .busy(busy[1]), .done(done[1]), .sum_mask(sm[1]), .carry_mask(cm[1]),
        .detected_mask(dm[1]), .detect_count(dc[1]), .vec_count(vc[1])
    );

    fault_campaign_sequencer #(.FIRST_FAULT(2), .LAST_FAULT(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a[2]), .b(b[2]), .cin(cin[2]),
        .fault_select(fs[2]), .fault_sum_detected(sd[2]), .fault_carry_detected(cd[2]),
        .busy(busy[2]), .done(done[2]), .sum_mask(sm[2]), .carry_mask(cm[2]),
        .detected_mask(dm[2]), .detect_count(dc[2]), .vec_count(vc[2])
    );

    typedef struct {
        logic [7:0] sm;
        logic [7:0] cm;
        logic [7:0] dm;
        logic [3:0] dc;
        logic [6:0] vc;
        int         done_cyc;
    } res_t;

    res_t       res_q [$];
    logic [5:0] trc_q [$];
    int         idle_q [$];

    int   cyc = 0;
    int   act = -1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wd = 0;
    logic done_prev [ND];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [42:0] all_outs(int d);
        return {busy[d], done[d], a[d], b[d], cin[d], fs[d], sm[d], cm[d], dm[d], dc[d], vc[d]};
    endfunction

    // Monitor: compares presented stimulus and completed results against the queues.
    always @(negedge clk) begin
        if (idle_q.size() > 0) begin
            int d;
            d = idle_q.pop_front();
            chk($sformatf("idle_outputs_dut%0d", d), 64'(all_outs(d)), 64'd0);
        end
        if (act >= 0) begin
            if (busy[act]) begin
                if (trc_q.size() == 0) begin
                    chk("trace_extra_vector", 64'(1), 64'(0));
                end else begin
                    chk("stimulus", 64'({fs[act], a[act], b[act], cin[act]}), 64'(trc_q.pop_front()));
                end
            end
            if (done[act] && !done_prev[act]) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("sum_mask",      64'(sm[act]), 64'(r.sm));
                    chk("carry_mask",    64'(cm[act]), 64'(r.cm));
                    chk("detected_mask", 64'(dm[act]), 64'(r.dm));
                    chk("detect_count",  64'(dc[act]), 64'(r.dc));
                    chk("vec_count",     64'(vc[act]), 64'(r.vc));
                    chk("done_cycle",    64'(cyc),     64'(r.done_cyc));
                    chk("trace_left",    64'(trc_q.size()), 64'(0));
                    trc_q.delete();
                end
            end
        end
        if (res_q.size() > 0) begin
            wd++;
            if (wd > 300) begin
                chk("done_timeout", 64'(0), 64'(1));
                void'(res_q.pop_front());
                trc_q.delete();
                wd = 0;
            end
        end else begin
            wd = 0;
        end
        for (int i = 0; i < ND; i++) done_prev[i] = done[i];
    end

    task automatic build_trace(int m, int ff, int lf, bit stop);
        for (int f = ff; f <= lf; f++) begin
            for (int v = 0; v < 8; v++) begin
                trc_q.push_back({3'(f), 3'(v)});
                if (stop && (stub_sum(m, 3'(f), 3'(v)) || stub_carry(m))) break;
            end
        end
    endtask

    task automatic run_campaign(int d, int m, int ff, int lf, bit stop,
                                logic [7:0] esm, logic [7:0] ecm, logic [7:0] edm,
                                logic [3:0] edc, logic [6:0] evc, int n, bit repulse);
        res_t r;
        mode[d] = m;
        act     = d;
        build_trace(m, ff, lf, stop);
        @(negedge clk);
        start[d] = 1'b1;
        r.sm = esm; r.cm = ecm; r.dm = edm; r.dc = edc; r.vc = evc;
        r.done_cyc = cyc + 1 + n;
        res_q.push_back(r);
        @(negedge clk);
        start[d] = 1'b0;
        if (repulse) begin
            repeat (10) @(negedge clk);
            start[d] = 1'b1;
            @(negedge clk);
            start[d] = 1'b0;
        end
        while (res_q.size() != 0) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < ND; i++) begin
            start[i] = 1'b0;
            mode[i]  = 0;
            done_prev[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ND; i++) idle_q.push_back(i);
        repeat (4) @(negedge clk);

        // Full sweep, no detection, with an ignored mid-run start pulse
        run_campaign(0, 0, 0, 7, 1'b1, 8'h00, 8'h00, 8'h00, 4'd0, 7'd64, 64, 1'b1);
        // Single sum detection at fault 3 vector 101
        run_campaign(0, 1, 0, 7, 1'b1, 8'h08, 8'h00, 8'h08, 4'd1, 7'd62, 62, 1'b0);
        // Restart from DONE, every vector detects
        run_campaign(0, 2, 0, 7, 1'b1, 8'hFF, 8'hFF, 8'hFF, 4'd8, 7'd8, 8, 1'b0);
        // Restart from DONE, results independent of previous campaign
        run_campaign(0, 0, 0, 7, 1'b1, 8'h00, 8'h00, 8'h00, 4'd0, 7'd64, 64, 1'b0);
        // No early stop: all 64 vectors, no over-count
        run_campaign(1, 2, 0, 7, 1'b0, 8'hFF, 8'hFF, 8'hFF, 4'd8, 7'd64, 64, 1'b0);
        // Restricted fault range 2..4
        run_campaign(2, 0, 2, 4, 1'b1, 8'h00, 8'h00, 8'h00, 4'd0, 7'd24, 24, 1'b0);

        // Reset mid-run after 20 vectors
        mode[0] = 1;
        act     = 0;
        build_trace(1, 0, 7, 1'b1);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (19) @(negedge clk);
        act = -1;
        trc_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_q.push_back(0);
        repeat (3) @(negedge clk);

        // Fresh campaign after reset
        run_campaign(0, 0, 0, 7, 1'b1, 8'h00, 8'h00, 8'h00, 4'd0, 7'd64, 64, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

endmodule
